// File: rtl/bsg_asic_clk_gen_pkg.sv
// Shared types and helpers for the multi-channel programmable clock generator.
package bsg_asic_clk_gen_pkg;

    // Configuration FSM: one pending slot, either free or holding a request.
    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/bsg_asic_clk_div_chan.sv
// One divided-clock channel: half-period counter, output toggle flop and the
// active divide value. A load replaces the divide value and restarts the
// output with a rising edge (or holds it low when the new value is 0).
// The owner must only assert i_load_v when o_at_rise is high.
module bsg_asic_clk_div_chan #(
    parameter int div_width_p = 8,
    parameter int reset_div_p = 1
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   i_load_v,
    input  logic [div_width_p-1:0] i_load_div,
    output logic                   o_clk,
    output logic [div_width_p-1:0] o_div,
    output logic                   o_at_rise
);

    localparam logic [div_width_p-1:0] RESET_DIV = reset_div_p[div_width_p-1:0];
    localparam logic [div_width_p-1:0] ONE       = {{(div_width_p-1){1'b0}}, 1'b1};

    logic [div_width_p-1:0] r_cnt;
    logic [div_width_p-1:0] r_div;
    logic                   r_clk;
    logic                   w_last;

    // End of a half period: the edge on which the output toggles.
    assign w_last = (r_cnt == (r_div - ONE));

    // Safe switch point: the edge where the output would rise, or any edge when stopped.
    assign o_at_rise = (r_div == '0) ? 1'b1 : (!r_clk && w_last);

    // Counter, toggle and divide value; a load always restarts at a clean rising edge.
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
            r_div <= RESET_DIV;
            r_clk <= 1'b0;
        end else if (i_load_v) begin
            r_div <= i_load_div;
            r_cnt <= '0;
            r_clk <= (i_load_div != '0);
        end else if (r_div == '0) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_cnt <= r_cnt + ONE;
        end
    end

    assign o_clk = r_clk;
    assign o_div = r_div;

endmodule

// File: rtl/bsg_asic_clk_gen.sv
// Multi-channel programmable clock generator. Each channel divides clk_i by
// 2*d; ratio changes are queued in a single pending slot and applied only at
// the target channel's rising boundary, so no runt pulses are produced.
// Reset release is expected to be synchronous to clk_i.
// Optional feature: define BSG_ASIC_CLK_GEN_STROBE_EN to add strobe_o, a
// registered one-cycle pulse marking each rising edge of clk_o.
module bsg_asic_clk_gen
    import bsg_asic_clk_gen_pkg::*;
#(
    parameter int channels_p  = 2,
    parameter int div_width_p = 8,
    parameter int reset_div_p = 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic                                  cfg_v_i,
    input  logic [chan_width(channels_p)-1:0]     cfg_chan_i,
    input  logic [div_width_p-1:0]                cfg_div_i,
    output logic                                  cfg_ready_o,
    output logic [channels_p-1:0]                 clk_o,
    output logic [channels_p*div_width_p-1:0]     div_o
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
    ,
    output logic [channels_p-1:0]                 strobe_o
`endif
);

    localparam int CW   = chan_width(channels_p);
    localparam int NPAD = 1 << CW;

    cfg_state_e             r_state;
    logic                   r_ready;
    logic [CW-1:0]          r_chan;
    logic [div_width_p-1:0] r_div_pend;

    logic [channels_p-1:0]  w_at_rise;
    logic [NPAD-1:0]        w_at_rise_pad;
    logic [channels_p-1:0]  w_load;
    logic                   w_chan_ok;
    logic                   w_apply;

    // Widen the boundary vector so any encodable channel index selects safely.
    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        w_at_rise_pad                   = '0;
        w_at_rise_pad[channels_p-1:0]   = w_at_rise;
    end

    assign w_chan_ok = (32'(r_chan) < channels_p);
    assign w_apply   = (r_state == PEND) && w_chan_ok && w_at_rise_pad[r_chan];

    // Config FSM: accept into the pending slot, release it on apply or on a bad channel.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_ready    <= 1'b1;
            r_chan     <= '0;
            r_div_pend <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cfg_v_i) begin
                        r_chan     <= cfg_chan_i;
                        r_div_pend <= cfg_div_i;
                        r_state    <= PEND;
                        r_ready    <= 1'b0;
                    end
                end
                PEND: begin
                    if (!w_chan_ok || w_at_rise_pad[r_chan]) begin
                        r_state <= IDLE;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o = r_ready;

    for (genvar g = 0; g < channels_p; g++) begin : g_chan
        assign w_load[g] = w_apply && (r_chan == CW'(g));

        bsg_asic_clk_div_chan #(
            .div_width_p (div_width_p),
            .reset_div_p (reset_div_p)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
            .i_load_v   (w_load[g]),
            .i_load_div (r_div_pend),
            .o_clk      (clk_o[g]),
            .o_div      (div_o[g*div_width_p +: div_width_p]),
            .o_at_rise  (w_at_rise[g])
        );

`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
        logic r_strobe;

        // Pulse in the cycle clk_o is first high: a natural rise or a load of a nonzero divide.
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                r_strobe <= 1'b0;
            end else begin
                r_strobe <= w_at_rise[g] &&
                            (w_load[g] ? (r_div_pend != '0)
                                       : (div_o[g*div_width_p +: div_width_p] != '0));
            end
        end

        assign strobe_o[g] = r_strobe;
`endif
    end

endmodule

// File: tb/tb_bsg_asic_clk_gen.sv
// Directed bench for bsg_asic_clk_gen (2 channels, plus a 3-channel instance
// for the out-of-range channel case). Strobe checks are active when
// BSG_ASIC_CLK_GEN_STROBE_EN is defined.
module tb_bsg_asic_clk_gen;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        cfg_v;
    logic        cfg_chan;
    logic [7:0]  cfg_div;
    logic        cfg_ready;
    logic [1:0]  clk_o;
    logic [15:0] div_o;

    logic        cfg2_v;
    logic [1:0]  cfg2_chan;
    logic [7:0]  cfg2_div;
    logic        cfg2_ready;
    logic [2:0]  clk2_o;
    logic [23:0] div2_o;

`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
    logic [1:0]  strobe_o;
    logic [2:0]  strobe2_o;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    int          e = 0;
    logic [1:0]  prev_exp = 2'b00;

    always #5 clk = ~clk;

    bsg_asic_clk_gen #(.channels_p(2), .div_width_p(8), .reset_div_p(1)) dut (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .cfg_v_i     (cfg_v),
        .cfg_chan_i  (cfg_chan),
        .cfg_div_i   (cfg_div),
        .cfg_ready_o (cfg_ready),
        .clk_o       (clk_o),
        .div_o       (div_o)
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
        ,
        .strobe_o    (strobe_o)
`endif
    );

    bsg_asic_clk_gen #(.channels_p(3), .div_width_p(8), .reset_div_p(1)) dut3 (
        .clk_i       (clk),
        .reset_n_i   (rst_n),
        .cfg_v_i     (cfg2_v),
        .cfg_chan_i  (cfg2_chan),
        .cfg_div_i   (cfg2_div),
        .cfg_ready_o (cfg2_ready),
        .clk_o       (clk2_o),
        .div_o       (div2_o)
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
        ,
        .strobe_o    (strobe2_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    // Expected schedule of the main scenario, derived by hand edge by edge.
    function automatic logic exp_c0(input int k);
        if (k <= 14) return k[0];
        if (k <= 19) return 1'b0;
        return ((k - 20) % 4) < 2;
    endfunction

    function automatic logic exp_c1(input int k);
        if (k <= 6)  return k[0];
        if (k <= 30) return ((k - 7) % 6) < 3;
        return ((k - 31) % 10) < 5;
    endfunction

    function automatic logic exp_ready(input int k);
        return !(k == 5 || k == 6 || k == 14 || k == 19 || (k >= 25 && k <= 30) || k == 42);
    endfunction

    function automatic logic [15:0] exp_div(input int k);
        if (k < 7)   return 16'h0101;
        if (k < 15)  return 16'h0301;
        if (k < 20)  return 16'h0300;
        if (k < 31)  return 16'h0302;
        return 16'h0502;
    endfunction

    task automatic check_clk(input string tag, input logic [1:0] exp);
        check({tag, " clk_o"}, 32'(clk_o), 32'(exp));
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
        check({tag, " strobe_o"}, 32'(strobe_o), 32'(exp & ~prev_exp));
`endif
        prev_exp = exp;
    endtask

    task automatic drive_cfg(input logic v, input logic ch, input logic [7:0] d);
        cfg_v    = v;
        cfg_chan = ch;
        cfg_div  = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive_cfg(1'b0, 1'b0, 8'd0);
        cfg2_v = 1'b0; cfg2_chan = 2'd0; cfg2_div = 8'd0;

        // Reset state.
        repeat (3) tick();
        check_clk("reset", 2'b00);
        check("reset div_o", 32'(div_o), 32'h0101);
        check("reset ready", 32'(cfg_ready), 32'd1);
        check("reset dut3 div_o", 32'(div2_o), 32'h010101);

        // Release, then run the directed config sequence edge by edge.
        rst_n = 1'b1;
        e = 0;
        prev_exp = 2'b00;
        for (int k = 1; k <= 42; k++) begin
            tick();
            check_clk("main", {exp_c1(e), exp_c0(e)});
            check("main ready", 32'(cfg_ready), 32'(exp_ready(e)));
            check("main div_o", 32'(div_o), 32'(exp_div(e)));
            case (e)
                4:  drive_cfg(1'b1, 1'b1, 8'd3);
                5:  drive_cfg(1'b0, 1'b0, 8'd0);
                13: drive_cfg(1'b1, 1'b0, 8'd0);
                14: drive_cfg(1'b0, 1'b0, 8'd0);
                18: drive_cfg(1'b1, 1'b0, 8'd2);
                19: drive_cfg(1'b0, 1'b0, 8'd0);
                24: drive_cfg(1'b1, 1'b1, 8'd5);
                25: drive_cfg(1'b1, 1'b1, 8'd7);
                30: drive_cfg(1'b0, 1'b0, 8'd0);
                41: drive_cfg(1'b1, 1'b1, 8'd9);
                42: drive_cfg(1'b0, 1'b0, 8'd0);
                default: ;
            endcase
        end

        // Reset mid-operation: chan1 high, d=9 pending.
        #2 rst_n = 1'b0;
        #1;
        check("midreset clk_o", 32'(clk_o), 32'd0);
        check("midreset div_o", 32'(div_o), 32'h0101);
        check("midreset ready", 32'(cfg_ready), 32'd1);
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
        check("midreset strobe_o", 32'(strobe_o), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        e = 0;
        prev_exp = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_clk("post", {e[0], e[0]});
            check("post div_o", 32'(div_o), 32'h0101);
            check("post ready", 32'(cfg_ready), 32'd1);
            check("dut3 clk_o", 32'(clk2_o), 32'({3{e[0]}}));
            check("dut3 div_o", 32'(div2_o), 32'h010101);
            check("dut3 ready", 32'(cfg2_ready), 32'(e != 3));
`ifdef BSG_ASIC_CLK_GEN_STROBE_EN
            check("dut3 strobe_o", 32'(strobe2_o), 32'({3{e[0]}}));
`endif
            if (e == 2) begin
                cfg2_v = 1'b1; cfg2_chan = 2'd3; cfg2_div = 8'd5;
            end else begin
                cfg2_v = 1'b0; cfg2_chan = 2'd0; cfg2_div = 8'd0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
